systolic_result_drain: RTL and testbench

- Output-side counterpart of the PE operand feed: reads the accumulated C results of one row of N PEs and returns them to the host as a serial valid/ready stream.
- On a CAPTURE pulse it snapshots all N C values into a shadow buffer and pulses CLEAR_PE so the row can start the next accumulation.
- It then streams the buffered values out one per handshake, index 0 first.
- Sits between the PE row's C outputs and the host/readback logic.

---
 rtl/systolic_result_drain.sv | 131 +++++++++++++
 tb/tb_systolic_result_drain.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// Result drain for one PE row: snapshots N accumulated C values on a capture
// and streams them to the host one word per valid/ready handshake, index 0 first.
module systolic_result_drain #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic [N*DATA_W-1:0] C_IN,
    input  logic                CAPTURE,
    output logic                CLEAR_PE,
    output logic                BUSY,
    output logic [DATA_W-1:0]   OUT_DATA,
    output logic [IDX_W-1:0]    OUT_INDEX,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic                OUT_LAST,
    output logic                OVERRUN,
    output logic [0:0]          STATE_DBG
);

    // Output handshake: a word moves on every rising edge where OUT_VALID and
    // OUT_READY are both high; while OUT_VALID && !OUT_READY the word, its index
    // and OUT_LAST are held unchanged. OUT_VALID never drops without a transfer
    // unless RESET is asserted.

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_SEND  = 1'b1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              clear_q, clear_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] buf_q [N];
    logic [DATA_W-1:0] buf_d [N];

    logic capture_fire;
    logic xfer;
    logic at_last;
    logic load;

    always_comb begin
        capture_fire = CAPTURE && ENABLE;
        xfer         = (state_q == ST_SEND) && OUT_READY;
        at_last      = (idx_q == IDX_LAST);

        state_d   = state_q;
        idx_d     = idx_q;
        clear_d   = 1'b0;
        overrun_d = overrun_q;
        load      = 1'b0;
        for (int i = 0; i < N; i++) begin
            buf_d[i] = buf_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (capture_fire) begin
                    load = 1'b1;
                end
            end
            ST_SEND: begin
                if (xfer && at_last) begin
                    // A capture on the final transfer chains straight into the next row.
                    if (capture_fire) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (capture_fire) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        if (load) begin
            state_d = ST_SEND;
            idx_d   = '0;
            clear_d = 1'b1;
            for (int i = 0; i < N; i++) begin
                buf_d[i] = C_IN[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            clear_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            clear_q   <= clear_d;
            overrun_q <= overrun_d;
        end
    end

    // Buffer contents are meaningless until a capture, so it carries no reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            buf_q[i] <= buf_d[i];
        end
    end

    always_comb begin
        OUT_VALID = (state_q == ST_SEND);
        BUSY      = OUT_VALID;
        OUT_INDEX = idx_q;
        OUT_DATA  = OUT_VALID ? buf_q[idx_q] : '0;
        OUT_LAST  = OUT_VALID && at_last;
        CLEAR_PE  = clear_q;
        OVERRUN   = overrun_q;
        STATE_DBG = state_q;
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: a vector table for the N=4 instance
// plus a hand-written sequence for the single-element N=1 instance.
module tb_systolic_result_drain;

    localparam int DW = 32;
    localparam int N4 = 4;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic            rst, en, cap, rdy;
    logic [N4*DW-1:0] cin;
    logic            clr, busy, vld, last, ovr;
    logic [DW-1:0]   data;
    logic [1:0]      idx;
    logic [0:0]      st;

    systolic_result_drain #(.DATA_W(DW), .N(N4)) dut (
        .CLK(clk), .RESET(rst), .ENABLE(en), .C_IN(cin), .CAPTURE(cap),
        .CLEAR_PE(clr), .BUSY(busy), .OUT_DATA(data), .OUT_INDEX(idx),
        .OUT_VALID(vld), .OUT_READY(rdy), .OUT_LAST(last), .OVERRUN(ovr),
        .STATE_DBG(st)
    );

    // N=1 instance
    logic          rst1, en1, cap1, rdy1;
    logic [DW-1:0] cin1;
    logic          clr1, busy1, vld1, last1, ovr1;
    logic [DW-1:0] data1;
    logic [0:0]    idx1;
    logic [0:0]    st1;

    systolic_result_drain #(.DATA_W(DW), .N(1)) dut1 (
        .CLK(clk), .RESET(rst1), .ENABLE(en1), .C_IN(cin1), .CAPTURE(cap1),
        .CLEAR_PE(clr1), .BUSY(busy1), .OUT_DATA(data1), .OUT_INDEX(idx1),
        .OUT_VALID(vld1), .OUT_READY(rdy1), .OUT_LAST(last1), .OVERRUN(ovr1),
        .STATE_DBG(st1)
    );

    typedef struct {
        logic            rst, cap, en, rdy;
        logic [N4*DW-1:0] cin;
        logic            clr, busy, vld;
        logic [DW-1:0]   data;
        logic [1:0]      idx;
        logic            last, ovr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [N4*DW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic void add(input logic r, c, e, y, input logic [N4*DW-1:0] ci,
                                input logic xc, xb, xv, input logic [DW-1:0] xd,
                                input logic [1:0] xi, input logic xl, xo);
        vec_t v;
        v.rst = r; v.cap = c; v.en = e; v.rdy = y; v.cin = ci;
        v.clr = xc; v.busy = xb; v.vld = xv; v.data = xd; v.idx = xi;
        v.last = xl; v.ovr = xo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    logic [N4*DW-1:0] ca, cb, cj, cf;

    initial begin
        rst = 1'b1; en = 1'b0; cap = 1'b0; rdy = 1'b0; cin = '0;
        rst1 = 1'b1; en1 = 1'b0; cap1 = 1'b0; rdy1 = 1'b0; cin1 = '0;

        ca = pack4(10, 11, 12, 13);
        cb = pack4(20, 21, 22, 23);
        cj = pack4(32'hdead_beef, 32'hcafe_f00d, 32'h1234_5678, 32'hffff_ffff);
        cf = pack4(5, 6, 7, 8);

        //   rst cap en rdy cin  clr busy vld data idx last ovr
        // reset and idle
        add(1, 0, 0, 0, '0,  0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 1, '0,  0, 0, 0, 0,  0, 0, 0);
        // basic drain; C_IN junk after capture must not leak into the stream
        add(0, 1, 1, 1, ca,  1, 1, 1, 10, 0, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 11, 1, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 12, 2, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 13, 3, 1, 0);
        add(0, 0, 1, 1, cj,  0, 0, 0, 0,  0, 0, 0);
        // capture with ENABLE low is ignored
        add(0, 1, 0, 1, ca,  0, 0, 0, 0,  0, 0, 0);
        add(0, 1, 0, 1, ca,  0, 0, 0, 0,  0, 0, 0);
        // backpressure at index 1, including a gated capture during the stall
        add(0, 1, 1, 1, ca,  1, 1, 1, 10, 0, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 11, 1, 0, 0);
        add(0, 0, 1, 0, cj,  0, 1, 1, 11, 1, 0, 0);
        add(0, 1, 0, 0, cb,  0, 1, 1, 11, 1, 0, 0);
        add(0, 0, 1, 0, cj,  0, 1, 1, 11, 1, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 12, 2, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 13, 3, 1, 0);
        add(0, 0, 1, 1, cj,  0, 0, 0, 0,  0, 0, 0);
        // overrun: capture at index 2 is dropped, OVERRUN is sticky
        add(0, 1, 1, 1, ca,  1, 1, 1, 10, 0, 0, 0);
        add(0, 0, 1, 1, ca,  0, 1, 1, 11, 1, 0, 0);
        add(0, 0, 1, 1, ca,  0, 1, 1, 12, 2, 0, 0);
        add(0, 1, 1, 1, cb,  0, 1, 1, 13, 3, 1, 1);
        add(0, 0, 1, 1, cb,  0, 0, 0, 0,  0, 0, 1);
        add(0, 0, 1, 1, cb,  0, 0, 0, 0,  0, 0, 1);
        // reset clears OVERRUN and outranks a simultaneous capture
        add(1, 1, 1, 1, ca,  0, 0, 0, 0,  0, 0, 0);
        // back-to-back: capture on the final transfer reloads with no bubble
        add(0, 1, 1, 1, ca,  1, 1, 1, 10, 0, 0, 0);
        add(0, 0, 1, 1, ca,  0, 1, 1, 11, 1, 0, 0);
        add(0, 0, 1, 1, ca,  0, 1, 1, 12, 2, 0, 0);
        add(0, 0, 1, 1, ca,  0, 1, 1, 13, 3, 1, 0);
        add(0, 1, 1, 1, cb,  1, 1, 1, 20, 0, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 21, 1, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 22, 2, 0, 0);
        add(0, 0, 1, 1, cj,  0, 1, 1, 23, 3, 1, 0);
        add(0, 0, 1, 1, cj,  0, 0, 0, 0,  0, 0, 0);
        // reset mid-stream at index 2, then a clean stream with ENABLE low
        add(0, 1, 1, 1, ca,  1, 1, 1, 10, 0, 0, 0);
        add(0, 0, 1, 1, ca,  0, 1, 1, 11, 1, 0, 0);
        add(0, 0, 1, 1, ca,  0, 1, 1, 12, 2, 0, 0);
        add(1, 1, 1, 1, cf,  0, 0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 1, cf,  1, 1, 1, 5,  0, 0, 0);
        add(0, 0, 0, 1, cj,  0, 1, 1, 6,  1, 0, 0);
        add(0, 0, 0, 1, cj,  0, 1, 1, 7,  2, 0, 0);
        add(0, 0, 0, 1, cj,  0, 1, 1, 8,  3, 1, 0);
        add(0, 0, 0, 1, cj,  0, 0, 0, 0,  0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; cap = vecs[i].cap; en = vecs[i].en;
            rdy = vecs[i].rdy; cin = vecs[i].cin;
            @(posedge clk);
            #1;
            check($sformatf("v%0d clear_pe", i), 32'(clr),  32'(vecs[i].clr));
            check($sformatf("v%0d busy", i),     32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d state", i),    32'(st),   32'(vecs[i].busy));
            check($sformatf("v%0d out_valid", i), 32'(vld), 32'(vecs[i].vld));
            check($sformatf("v%0d out_data", i), data,      vecs[i].data);
            check($sformatf("v%0d out_index", i), 32'(idx), 32'(vecs[i].idx));
            check($sformatf("v%0d out_last", i), 32'(last), 32'(vecs[i].last));
            check($sformatf("v%0d overrun", i),  32'(ovr),  32'(vecs[i].ovr));
        end

        // N=1: every word is the last word and the index never leaves 0
        @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk); #1;
        check("n1 reset valid", 32'(vld1), 0);
        check("n1 reset data", data1, 0);

        @(negedge clk);
        rst1 = 1'b0; en1 = 1'b1; cap1 = 1'b1; rdy1 = 1'b0; cin1 = 32'd99;
        @(posedge clk); #1;
        check("n1 cap clear_pe", 32'(clr1), 1);
        check("n1 cap valid", 32'(vld1), 1);
        check("n1 cap data", data1, 99);
        check("n1 cap last", 32'(last1), 1);
        check("n1 cap index", 32'(idx1), 0);

        @(negedge clk);
        cap1 = 1'b0; cin1 = 32'd1;
        @(posedge clk); #1;
        check("n1 stall clear_pe", 32'(clr1), 0);
        check("n1 stall data", data1, 99);
        check("n1 stall last", 32'(last1), 1);

        @(negedge clk);
        cap1 = 1'b1; rdy1 = 1'b1; cin1 = 32'd77;
        @(posedge clk); #1;
        check("n1 b2b clear_pe", 32'(clr1), 1);
        check("n1 b2b data", data1, 77);
        check("n1 b2b last", 32'(last1), 1);
        check("n1 b2b overrun", 32'(ovr1), 0);

        @(negedge clk);
        cap1 = 1'b1; rdy1 = 1'b0; cin1 = 32'd55;
        @(posedge clk); #1;
        check("n1 ovr flag", 32'(ovr1), 1);
        check("n1 ovr data", data1, 77);
        check("n1 ovr clear_pe", 32'(clr1), 0);

        @(negedge clk);
        cap1 = 1'b0; rdy1 = 1'b1;
        @(posedge clk); #1;
        check("n1 done valid", 32'(vld1), 0);
        check("n1 done busy", 32'(busy1), 0);
        check("n1 done overrun", 32'(ovr1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
